// File: rtl/sigdecode_h_ctrl.sv
// Hint-vector decode controller: validates the K cumulative hint counts, then issues
// one (base, count) command per polynomial to the datapath and collects completions.
module sigdecode_h_ctrl #(
    parameter int OMEGA = 75,
    parameter int K     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 zeroize,
    input  logic                 start_i,
    input  logic [K-1:0][7:0]    hintsum_i,
    output logic                 poly_valid_o,
    input  logic                 poly_ready_i,
    output logic [$clog2(K)-1:0] poly_idx_o,
    output logic [7:0]           poly_base_o,
    output logic [7:0]           poly_cnt_o,
    output logic                 poly_last_o,
    input  logic                 poly_done_i,
    input  logic                 dp_err_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);
    localparam int              IW       = $clog2(K);
    localparam logic [IW-1:0]   LAST_IDX = IW'(K - 1);
    localparam logic [7:0]      OMEGA_B  = 8'(OMEGA);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HINTSUM = 3'd1,
        INIT    = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [7:0]      hs_r [K];
    logic [IW-1:0]   idx_r, idx_s;
    logic [IW-1:0]   chk_r, chk_s;
    logic [7:0]      prev_r, prev_s;
    logic            err_s;
    logic            latch_s;
    logic [7:0]      base_s, cnt_s;

    // Next-state and next-register-value logic for the controller FSM.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        chk_s   = chk_r;
        prev_s  = prev_r;
        err_s   = error_o;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    latch_s = 1'b1;
                    err_s   = 1'b0;
                    chk_s   = {IW{1'b0}};
                    prev_s  = 8'd0;
                    idx_s   = {IW{1'b0}};
                    state_s = HINTSUM;
                end else begin
                    state_s = IDLE;
                end
            end
            HINTSUM: begin
                // A count below its predecessor or above OMEGA is a malformed signature.
                if ((hs_r[chk_r] < prev_r) || (hs_r[chk_r] > OMEGA_B)) begin
                    err_s   = 1'b1;
                    state_s = DONE;
                end else if (chk_r == LAST_IDX) begin
                    idx_s   = {IW{1'b0}};
                    state_s = INIT;
                end else begin
                    chk_s  = chk_r + {{(IW-1){1'b0}}, 1'b1};
                    prev_s = hs_r[chk_r];
                end
            end
            INIT: begin
                if (poly_ready_i) begin
                    state_s = EXEC;
                end else begin
                    state_s = INIT;
                end
            end
            EXEC: begin
                if (poly_done_i) begin
                    if (dp_err_i) begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
                        state_s = INIT;
                    end
                end else begin
                    state_s = EXEC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Command fields for the upcoming polynomial; the hint-count check keeps cnt from wrapping.
    always_comb begin
        base_s = 8'd0;
        cnt_s  = 8'd0;
        if (state_s == INIT) begin
            if (idx_s == {IW{1'b0}}) begin
                base_s = 8'd0;
            end else begin
                base_s = hs_r[idx_s - {{(IW-1){1'b0}}, 1'b1}];
            end
            cnt_s = hs_r[idx_s] - base_s;
        end else begin
            base_s = 8'd0;
            cnt_s  = 8'd0;
        end
    end

    // State, working registers and registered outputs; reset/zeroize clear everything.
    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            state_r      <= IDLE;
            idx_r        <= {IW{1'b0}};
            chk_r        <= {IW{1'b0}};
            prev_r       <= 8'd0;
            for (int i = 0; i < K; i++) hs_r[i] <= 8'd0;
            poly_valid_o <= 1'b0;
            poly_idx_o   <= {IW{1'b0}};
            poly_base_o  <= 8'd0;
            poly_cnt_o   <= 8'd0;
            poly_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            chk_r   <= chk_s;
            prev_r  <= prev_s;
            if (latch_s) begin
                for (int i = 0; i < K; i++) hs_r[i] <= hintsum_i[i];
            end
            poly_valid_o <= (state_s == INIT);
            poly_idx_o   <= (state_s == INIT) ? idx_s : {IW{1'b0}};
            poly_base_o  <= base_s;
            poly_cnt_o   <= cnt_s;
            poly_last_o  <= (state_s == INIT) && (idx_s == LAST_IDX);
            busy_o       <= (state_s != IDLE);
            done_o       <= (state_s == DONE);
            error_o      <= err_s;
        end
    end
endmodule

// File: tb/tb_sigdecode_h_ctrl.sv
// Directed bench for sigdecode_h_ctrl: nominal decode, hint-count errors, backpressure,
// datapath error, reset/zeroize behaviour, all against hand-computed expectations.
module tb_sigdecode_h_ctrl;
    logic            clk = 1'b0;
    logic            reset_n, zeroize, start_i;
    logic [7:0][7:0] hintsum_i;
    logic            poly_valid_o, poly_ready_i, poly_last_o;
    logic [2:0]      poly_idx_o;
    logic [7:0]      poly_base_o, poly_cnt_o;
    logic            poly_done_i, dp_err_i, busy_o, done_o, error_o;

    int vec = 0;
    int miscmp = 0;
    int cyc = 0;
    bit saw_valid;

    logic [7:0][7:0] hs_nom;
    logic [7:0][7:0] exp_base;
    logic [7:0][7:0] exp_cnt;

    sigdecode_h_ctrl #(.OMEGA(75), .K(8)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start_i(start_i),
        .hintsum_i(hintsum_i), .poly_valid_o(poly_valid_o), .poly_ready_i(poly_ready_i),
        .poly_idx_o(poly_idx_o), .poly_base_o(poly_base_o), .poly_cnt_o(poly_cnt_o),
        .poly_last_o(poly_last_o), .poly_done_i(poly_done_i), .dp_err_i(dp_err_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0][7:0] hs);
        hintsum_i = hs;
        start_i   = 1'b1;
        cyc       = 0;
        tick();
        start_i   = 1'b0;
    endtask

    // Runs commands 0..7; stall_p gets 5 cycles of backpressure, err_p reports dp_err,
    // stop_p returns in its first EXEC cycle without completing it.
    task automatic run_cmds(input int stall_p, input int err_p, input int stop_p);
        for (int i = 0; i < 8; i++) begin
            for (int t = 0; t < 20 && !poly_valid_o; t++) tick();
            chk($sformatf("valid%0d", i), poly_valid_o, 1);
            chk($sformatf("idx%0d", i), poly_idx_o, i);
            chk($sformatf("base%0d", i), poly_base_o, exp_base[i]);
            chk($sformatf("cnt%0d", i), poly_cnt_o, exp_cnt[i]);
            chk($sformatf("last%0d", i), poly_last_o, (i == 7) ? 1 : 0);
            if (i == stall_p) begin
                poly_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk("stall_valid", poly_valid_o, 1);
                    chk("stall_base", poly_base_o, exp_base[i]);
                    chk("stall_cnt", poly_cnt_o, exp_cnt[i]);
                    tick();
                end
                poly_ready_i = 1'b1;
                chk("stall_hold", poly_cnt_o, exp_cnt[i]);
            end
            // A done pulse coinciding with the handshake must be ignored.
            poly_done_i = (i == 1);
            tick();
            poly_done_i = 1'b0;
            chk($sformatf("exec_valid%0d", i), poly_valid_o, 0);
            if (i == stop_p) return;
            poly_done_i = 1'b1;
            dp_err_i    = (i == err_p);
            tick();
            poly_done_i = 1'b0;
            dp_err_i    = 1'b0;
            if (i == err_p) return;
        end
    endtask

    initial begin
        hs_nom   = {8'd75, 8'd60, 8'd40, 8'd20, 8'd10, 8'd3, 8'd3, 8'd1};
        exp_base = {8'd60, 8'd40, 8'd20, 8'd10, 8'd3, 8'd3, 8'd1, 8'd0};
        exp_cnt  = {8'd15, 8'd20, 8'd20, 8'd10, 8'd7, 8'd0, 8'd2, 8'd1};
        reset_n = 1'b0; zeroize = 1'b0; start_i = 1'b0; hintsum_i = '0;
        poly_ready_i = 1'b1; poly_done_i = 1'b0; dp_err_i = 1'b0;
        tick(); tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", poly_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", error_o, 0);
        reset_n = 1'b1;
        tick();

        // Nominal decode: done_o at cycle 3K+1 = 25.
        do_start(hs_nom);
        chk("nom_busy", busy_o, 1);
        run_cmds(-1, -1, -1);
        chk("nom_done", done_o, 1);
        chk("nom_cycle", cyc, 25);
        chk("nom_err", error_o, 0);
        tick();
        chk("nom_done_pulse", done_o, 0);
        chk("nom_idle", busy_o, 0);

        // Entry 2 above OMEGA.
        hintsum_i = hs_nom; hintsum_i[2] = 8'd76;
        do_start(hintsum_i);
        saw_valid = 1'b0;
        for (int t = 0; t < 40 && !done_o; t++) begin
            saw_valid |= poly_valid_o;
            tick();
        end
        chk("omega_done", done_o, 1);
        chk("omega_cycle", cyc, 4);
        chk("omega_err", error_o, 1);
        chk("omega_novalid", saw_valid, 0);
        tick();

        // Non-monotone at entry 1; also clears the previous error on start.
        hintsum_i = hs_nom; hintsum_i[0] = 8'd5; hintsum_i[1] = 8'd4;
        do_start(hintsum_i);
        chk("mono_errclr", error_o, 0);
        saw_valid = 1'b0;
        for (int t = 0; t < 40 && !done_o; t++) begin
            saw_valid |= poly_valid_o;
            tick();
        end
        chk("mono_cycle", cyc, 3);
        chk("mono_err", error_o, 1);
        chk("mono_novalid", saw_valid, 0);
        tick();

        // Backpressure at poly 3 delays done_o by 5.
        do_start(hs_nom);
        run_cmds(3, -1, -1);
        chk("stall_done", done_o, 1);
        chk("stall_cycle", cyc, 30);
        chk("stall_err", error_o, 0);
        tick();

        // Datapath error on poly 2.
        do_start(hs_nom);
        run_cmds(-1, 2, -1);
        chk("dperr_done", done_o, 1);
        chk("dperr_err", error_o, 1);
        chk("dperr_cycle", cyc, 15);
        chk("dperr_novalid", poly_valid_o, 0);
        tick();
        chk("dperr_sticky", error_o, 1);
        chk("dperr_idle", busy_o, 0);

        // New start clears error; reset in EXEC of poly 4, start while busy ignored.
        do_start(hs_nom);
        chk("restart_errclr", error_o, 0);
        run_cmds(-1, -1, 4);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_start_busy", busy_o, 1);
        chk("busy_start_valid", poly_valid_o, 0);
        chk("busy_start_done", done_o, 0);
        reset_n = 1'b0; start_i = 1'b1;
        tick();
        reset_n = 1'b1; start_i = 1'b0;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_idx", poly_idx_o, 0);
        tick();
        chk("rst_prio_busy", busy_o, 0);

        // Zeroize mid-HINTSUM.
        do_start(hs_nom);
        tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_busy", busy_o, 0);
        chk("zero_err", error_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
